sdram_req_arbiter: RTL

Request arbiter and refresh scheduler in front of the SDRAM controller FSM. It shares the controller between two application ports (p0, p1), each of which can issue burst write and burst read requests. It also injects periodic auto-refresh requests. Exactly one operation is outstanding at a time: the arbiter grants, forwards the latched address, and holds until the controller reports done.

---
 rtl/sdram_req_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_req_arbiter
// Purpose  : Two-port burst request arbiter and auto-refresh scheduler that
//            keeps exactly one operation outstanding at the SDRAM controller.
// Option   : define SDRAM_ARB_FIXED_PRIO_EN for fixed p0 > p1 priority
//            (default build arbitrates round-robin between the ports).
// Revision : 1.0  initial release
// ============================================================================
module sdram_req_arbiter #(
  parameter int REFRESH_CYCLES = 780,
  parameter int REF_PEND_MAX   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_p0_wr_req,
  input  logic        i_p0_rd_req,
  input  logic [23:0] i_p0_addr,
  input  logic        i_p1_wr_req,
  input  logic        i_p1_rd_req,
  input  logic [23:0] i_p1_addr,
  output logic        o_p0_grant,
  output logic        o_p1_grant,
  output logic        o_p0_done,
  output logic        o_p1_done,
  output logic        o_wr_req,
  output logic        o_rd_req,
  output logic        o_ref_req,
  output logic [23:0] o_addr,
  input  logic        i_wr_done,
  input  logic        i_rd_done,
  input  logic        i_ref_done,
  output logic        o_ref_overflow
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_REF  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [15:0] C_TIMER_LAST = 16'(REFRESH_CYCLES - 1);
  localparam logic [3:0]  C_PEND_MAX   = 4'(REF_PEND_MAX);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  tag_q, tag_d;   // {owner port, op is read}
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic        ref_req_q, ref_req_d;
  logic        p0_grant_q, p0_grant_d;
  logic        p1_grant_q, p1_grant_d;
  logic        p0_done_q, p0_done_d;
  logic        p1_done_q, p1_done_d;

  logic ref_tick, ref_served;
  logic p0_any, p1_any, pick_p1, sel_wr;
  logic op_is_rd, op_done, op_issued;

  assign p0_any = i_p0_wr_req | i_p0_rd_req;
  assign p1_any = i_p1_wr_req | i_p1_rd_req;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign pick_p1 = !p0_any;
`else
  logic rr_q, rr_d;   // 1 = port 1 preferred
  assign pick_p1 = rr_q ? p1_any : !p0_any;
`endif

  assign sel_wr    = pick_p1 ? i_p1_wr_req : i_p0_wr_req;
  assign op_is_rd  = tag_q[0];
  assign op_done   = op_is_rd ? i_rd_done : i_wr_done;
  assign op_issued = wr_req_q | rd_req_q;

  always_comb begin
    ref_tick = 1'b0;
    timer_d  = timer_q;
    if (i_init_done) begin
      if (timer_q == C_TIMER_LAST) begin
        timer_d  = '0;
        ref_tick = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
    ref_served = (state_q == S_REF) && ref_req_q && i_ref_done;
    pend_d = pend_q;
    // A tick coinciding with a completed refresh cancels out.
    if (ref_tick && !ref_served && (pend_q != C_PEND_MAX)) begin
      pend_d = pend_q + 4'd1;
    end else if (ref_served && !ref_tick) begin
      pend_d = pend_q - 4'd1;
    end
    ovf_d = ovf_q | (pend_d == C_PEND_MAX);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    wr_req_d   = 1'b0;
    rd_req_d   = 1'b0;
    ref_req_d  = 1'b0;
    p0_grant_d = 1'b0;
    p1_grant_d = 1'b0;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    rr_d = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_init_done) state_d = S_ARB;
      end
      S_ARB: begin
        if (!i_init_done) begin
          state_d = S_IDLE;
        end else if (pend_q != 4'd0) begin
          state_d   = S_REF;
          ref_req_d = 1'b1;
        end else if (p0_any || p1_any) begin
          state_d    = sel_wr ? S_WR : S_RD;
          addr_d     = pick_p1 ? i_p1_addr : i_p0_addr;
          tag_d      = {pick_p1, !sel_wr};
          p0_grant_d = !pick_p1;
          p1_grant_d = pick_p1;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          rr_d = !pick_p1;
`endif
        end
      end
      // The grant cycle has no request out yet, so a done then is spurious.
      S_WR, S_RD: begin
        if (op_issued && op_done) begin
          state_d   = S_DONE;
          p0_done_d = !tag_q[1];
          p1_done_d = tag_q[1];
        end else begin
          wr_req_d = !op_is_rd;
          rd_req_d = op_is_rd;
        end
      end
      S_REF: begin
        if (ref_served) state_d = S_ARB;
        else            ref_req_d = 1'b1;
      end
      S_DONE: begin
        state_d = i_init_done ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      addr_q     <= '0;
      tag_q      <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      ref_req_q  <= 1'b0;
      p0_grant_q <= 1'b0;
      p1_grant_q <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      ref_req_q  <= ref_req_d;
      p0_grant_q <= p0_grant_d;
      p1_grant_q <= p1_grant_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign o_p0_grant     = p0_grant_q;
  assign o_p1_grant     = p1_grant_q;
  assign o_p0_done      = p0_done_q;
  assign o_p1_done      = p1_done_q;
  assign o_wr_req       = wr_req_q;
  assign o_rd_req       = rd_req_q;
  assign o_ref_req      = ref_req_q;
  assign o_addr         = addr_q;
  assign o_ref_overflow = ovf_q;

endmodule
`default_nettype wire
